// File: rtl/bmul_shadd32u.sv
// Unsigned radix-2 shift-add multiplier: one multiplier bit per cycle, full 2*WIDTH-bit product.
// Shares the start_in/busy/done handshake of the MULDIV restoring divider.
module bmul_shadd32u #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   input  logic               start_in,
   output logic [2*WIDTH-1:0] p_out,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      FINISH = 2'b00,
      LOOP   = 2'b01
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] reg_lo_q, reg_lo_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [CW-1:0]    count_q, count_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   sum;

   always_comb begin
      state_d  = state_q;
      acc_hi_d = acc_hi_q;
      reg_lo_d = reg_lo_q;
      mcand_d  = mcand_q;
      count_d  = count_q;
      done_d   = 1'b0;
      sum      = {1'b0, acc_hi_q} + (reg_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      case (state_q)
         FINISH: begin
            if (start_in) begin
               // A zero operand skips iteration entirely and completes in one cycle.
               if ((a_in == {WIDTH{1'b0}}) || (b_in == {WIDTH{1'b0}})) begin
                  acc_hi_d = {WIDTH{1'b0}};
                  reg_lo_d = {WIDTH{1'b0}};
                  done_d   = 1'b1;
               end else begin
                  mcand_d  = a_in;
                  reg_lo_d = b_in;
                  acc_hi_d = {WIDTH{1'b0}};
                  count_d  = {CW{1'b0}};
                  state_d  = LOOP;
               end
            end else begin
               state_d = FINISH;
            end
         end
         LOOP: begin
            // The carry out of sum lands in the MSB of acc_hi after the shift.
            {acc_hi_d, reg_lo_d} = {sum, reg_lo_q[WIDTH-1:1]};
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            if (count_q == CW'(WIDTH-1)) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end else begin
               state_d = LOOP;
            end
         end
         default: begin
            state_d = FINISH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FINISH;
         acc_hi_q <= {WIDTH{1'b0}};
         reg_lo_q <= {WIDTH{1'b0}};
         mcand_q  <= {WIDTH{1'b0}};
         count_q  <= {CW{1'b0}};
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_hi_q <= acc_hi_d;
         reg_lo_q <= reg_lo_d;
         mcand_q  <= mcand_d;
         count_q  <= count_d;
         done_q   <= done_d;
      end
   end

   assign p_out = {acc_hi_q, reg_lo_q};
   assign busy  = (state_q == LOOP);
   assign done  = done_q;

endmodule

// File: tb/tb_bmul_shadd32u.sv
// Scoreboard bench for bmul_shadd32u: expected products are queued at start and checked on done.
module tb_bmul_shadd32u;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        start_in;
   logic [63:0] p_out;
   logic        busy;
   logic        done;

   int          checks = 0;
   int          errors = 0;
   int          ncyc = 0;
   int          last_done_cyc = 0;
   int          done_cnt = 0;
   logic [63:0] sb_q[$];

   bmul_shadd32u #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .start_in(start_in),
      .p_out(p_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // One clock edge, then scoreboard drain: every done must match the oldest queued product.
   task automatic cycle();
      logic [63:0] exp_p;
      @(posedge clk);
      #1;
      ncyc++;
      if (done) begin
         done_cnt++;
         last_done_cyc = ncyc;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done p_out=%h expected no done", p_out);
         end else begin
            exp_p = sb_q.pop_front();
            if (p_out !== exp_p || busy !== 1'b0) begin
               errors++;
               $display("FAIL sb_product got=%h busy=%b expected=%h busy=0", p_out, busy, exp_p);
            end
         end
      end
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      a_in = a;
      b_in = b;
      start_in = 1'b1;
      sb_q.push_back(64'(a) * 64'(b));
      cycle();
      start_in = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int guard = 0;
      while (!done && guard < 100) begin
         cycle();
         guard++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_timeout done=%b expected done=1", name, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start_in = 1'b0; a_in = 32'd0; b_in = 32'd0;
      cycle();
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++;
         if (p_out !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle p_out=%h busy=%b done=%b expected 0/0/0", p_out, busy, done);
         end
      end
   endtask

   task automatic test_max();
      int busy_cnt = 0;
      int d0;
      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      d0 = done_cnt;
      while (busy && busy_cnt < 100) begin
         busy_cnt++;
         cycle();
      end
      checks++;
      if (busy_cnt != 32 || done !== 1'b1 || done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL max_latency busy_cycles=%0d done=%b expected 32 cycles then done=1", busy_cnt, done);
      end
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks++;
         if (p_out !== 64'hFFFF_FFFE_0000_0001 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL max_hold p_out=%h done=%b busy=%b expected fffffffe00000001/0/0", p_out, done, busy);
         end
      end
   endtask

   task automatic test_zero_bypass();
      launch(32'd12345, 32'd0);
      checks++;
      if (busy !== 1'b0 || done !== 1'b1 || p_out !== 64'd0) begin
         errors++;
         $display("FAIL zero_bypass busy=%b done=%b p_out=%h expected 0/1/0", busy, done, p_out);
      end
      launch(32'd0, 32'hDEAD_BEEF);
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL zero_bypass_a busy=%b done=%b expected 0/1", busy, done);
      end
      cycle();
      checks++;
      if (done !== 1'b0 || p_out !== 64'd0) begin
         errors++;
         $display("FAIL zero_after done=%b p_out=%h expected 0/0", done, p_out);
      end
   endtask

   task automatic test_ignore_start();
      int busy_cnt = 1;
      launch(32'd7, 32'd6);
      for (int i = 0; i < 4; i++) begin
         cycle();
         busy_cnt++;
      end
      a_in = 32'd3; b_in = 32'd3; start_in = 1'b1;
      cycle();
      busy_cnt++;
      start_in = 1'b0;
      while (busy && busy_cnt < 100) begin
         cycle();
         busy_cnt++;
      end
      checks++;
      if (busy_cnt != 33 || done !== 1'b1 || p_out !== 64'd42) begin
         errors++;
         $display("FAIL ignore_start samples=%0d done=%b p_out=%h expected 33/1/42", busy_cnt, done, p_out);
      end
   endtask

   task automatic test_abort();
      launch(32'h8000_0000, 32'd2);
      for (int i = 0; i < 9; i++) cycle();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre busy=%b expected 1", busy);
      end
      rst = 1'b1;
      sb_q.delete();
      cycle();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || p_out !== 64'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_state busy=%b p_out=%h done=%b expected 0/0/0", busy, p_out, done);
      end
      for (int i = 0; i < 40; i++) cycle();
      launch(32'h0001_0000, 32'h0001_0000);
      wait_done("abort_next");
      checks++;
      if (p_out !== 64'h0000_0001_0000_0000) begin
         errors++;
         $display("FAIL abort_next p_out=%h expected 0000000100000000", p_out);
      end
   endtask

   task automatic test_back_to_back();
      int first_done;
      a_in = 32'd5; b_in = 32'd9; start_in = 1'b1;
      sb_q.push_back(64'd45);
      cycle();
      a_in = 32'd11; b_in = 32'd13;
      sb_q.push_back(64'd143);
      wait_done("b2b_first");
      first_done = last_done_cyc;
      checks++;
      if (p_out !== 64'd45) begin
         errors++;
         $display("FAIL b2b_first p_out=%h expected 45", p_out);
      end
      cycle();
      start_in = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap busy=%b expected 1", busy);
      end
      wait_done("b2b_second");
      checks++;
      if (last_done_cyc - first_done != 33 || p_out !== 64'd143) begin
         errors++;
         $display("FAIL b2b_second interval=%0d p_out=%h expected 33/143", last_done_cyc - first_done, p_out);
      end
      cycle();
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 6; i++) begin
         a = $urandom();
         b = $urandom();
         launch(a, b);
         wait_done("rand");
         checks++;
         if (p_out !== 64'(a) * 64'(b)) begin
            errors++;
            $display("FAIL rand_product a=%h b=%h p_out=%h expected %h", a, b, p_out, 64'(a) * 64'(b));
         end
      end
   endtask

   initial begin
      test_reset();
      test_max();
      test_zero_bypass();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      test_random();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover count=%0d expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
